// File: rtl/ex_stage_md.sv
// Execute stage: operand forwarding, ALU, result/destination select, and a
// multi-cycle multiply/divide unit that owns the HI/LO registers.
module ex_stage_md #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int LINK_REG    = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alusrc,
  input  logic [1:0]       regdst,
  input  logic [3:0]       aluop,
  input  logic [2:0]       md_op,
  input  logic [1:0]       res_sel,
  input  logic [4:0]       rt,
  input  logic [4:0]       rd,
  input  logic [WIDTH-1:0] rd1,
  input  logic [WIDTH-1:0] rd2,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] pc,
  input  logic [1:0]       fwd_a,
  input  logic [1:0]       fwd_b,
  input  logic [WIDTH-1:0] wd_wb,
  input  logic [WIDTH-1:0] aluout_mem,
  output logic [4:0]       a3,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] tr_b,
  output logic             md_busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DIV  = 2'd2
  } md_state_e;

  md_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q;
  logic             sgn_q;

  logic [WIDTH-1:0] a_d, b_d, alu_d;
  logic             start_d;

  always_comb begin
    a_d = rd1;
    case (fwd_a)
      2'd1:    a_d = wd_wb;
      2'd2:    a_d = aluout_mem;
      default: a_d = rd1;
    endcase
    tr_b = rd2;
    case (fwd_b)
      2'd1:    tr_b = wd_wb;
      2'd2:    tr_b = aluout_mem;
      default: tr_b = rd2;
    endcase
    b_d = alusrc ? imm : tr_b;
  end

  always_comb begin
    alu_d = '0;
    case (aluop)
      4'd0:  alu_d = a_d + b_d;
      4'd1:  alu_d = a_d - b_d;
      4'd2:  alu_d = a_d | b_d;
      4'd3:  alu_d = a_d & b_d;
      4'd4:  alu_d = a_d ^ b_d;
      4'd5:  alu_d = ~(a_d | b_d);
      4'd6:  alu_d = {{(WIDTH-1){1'b0}}, ($signed(a_d) < $signed(b_d))};
      4'd7:  alu_d = {{(WIDTH-1){1'b0}}, (a_d < b_d)};
      4'd8:  alu_d = b_d << 16;
      4'd9:  alu_d = b_d << a_d[4:0];
      4'd10: alu_d = b_d >> a_d[4:0];
      4'd11: alu_d = $signed(b_d) >>> a_d[4:0];
      default: alu_d = '0;
    endcase
  end

  always_comb begin
    a3 = 5'd0;
    case (regdst)
      2'd0:    a3 = rt;
      2'd1:    a3 = rd;
      2'd2:    a3 = 5'(LINK_REG);
      default: a3 = 5'd0;
    endcase
    result = alu_d;
    case (res_sel)
      2'd1:    result = hi_q;
      2'd2:    result = lo_q;
      2'd3:    result = pc + WIDTH'(8);
      default: result = alu_d;
    endcase
  end

  // Signed divide is done on magnitudes so the most-negative / -1 case wraps predictably.
  logic [2*WIDTH-1:0] prod_d;
  logic [WIDTH-1:0]   a_mag, b_mag, q_mag, r_mag, quo_d, rem_d;
  logic               neg_a, neg_b;

  always_comb begin
    prod_d = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q} * {{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q};
    neg_a  = sgn_q & a_q[WIDTH-1];
    neg_b  = sgn_q & b_q[WIDTH-1];
    a_mag  = neg_a ? -a_q : a_q;
    b_mag  = neg_b ? -b_q : b_q;
    q_mag  = '0;
    r_mag  = '0;
    if (b_q != '0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    quo_d = (neg_a ^ neg_b) ? -q_mag : q_mag;
    rem_d = neg_a ? -r_mag : r_mag;
  end

  assign start_d = (state_q == S_IDLE) && (md_op >= 3'd1) && (md_op <= 3'd4);
  assign md_busy = start_d | (state_q != S_IDLE);
  assign hi      = hi_q;
  assign lo      = lo_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_d) begin
            a_q   <= a_d;
            b_q   <= b_d;
            sgn_q <= (md_op == 3'd1) || (md_op == 3'd3);
            if (md_op <= 3'd2) begin
              cnt_q   <= CNT_W'(MULT_CYCLES);
              state_q <= S_MULT;
            end else begin
              cnt_q   <= CNT_W'(DIV_CYCLES);
              state_q <= S_DIV;
            end
          end else if (md_op == 3'd5) begin
            hi_q <= a_d;
          end else if (md_op == 3'd6) begin
            lo_q <= a_d;
          end
        end
        S_MULT: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            hi_q    <= prod_d[2*WIDTH-1:WIDTH];
            lo_q    <= prod_d[WIDTH-1:0];
            state_q <= S_IDLE;
          end
        end
        S_DIV: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            if (b_q != '0) begin
              hi_q <= rem_d;
              lo_q <= quo_d;
            end
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
